ex_alu_stage: RTL

//  Execute stage of the MIPS pipeline, downstream of the ID-stage ALU decoder.
//  - Latches the decoded ALU control, operands, shift amount and destination into the ID/EX register.
//  - Computes the ALU result in EX.
//  - Registers the result into EX/MEM for the memory/writeback path.
//  - Handles stall/flush bubbles and flags undecodable ops.

---
 rtl/ex_alu_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: MIPS execute stage, made of the ID/EX register, the ALU and the EX/MEM register.
// Optional macro EX_BYPASS_EN adds an EX/MEM-to-EX operand bypass.
module ex_alu_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validD,
   input  logic [4:0]        alucontrolD,
   input  logic [DATA_W-1:0] srcaD,
   input  logic [DATA_W-1:0] srcbD,
   input  logic [REG_W-1:0]  saD,
   input  logic [REG_W-1:0]  rsD,
   input  logic [REG_W-1:0]  rtD,
   input  logic [REG_W-1:0]  writeregD,
   input  logic              regwriteD,
   input  logic              stallE,
   input  logic              flushE,
   output logic [DATA_W-1:0] aluresultE,
   output logic [REG_W-1:0]  writeregE,
   output logic              regwriteE,
   output logic              validM,
   output logic [DATA_W-1:0] aluresultM,
   output logic [REG_W-1:0]  writeregM,
   output logic              regwriteM,
   output logic              ri_exceptM
);

   localparam logic [4:0] SIG_ALU_AND  = 5'd0;
   localparam logic [4:0] SIG_ALU_OR   = 5'd1;
   localparam logic [4:0] SIG_ALU_XOR  = 5'd2;
   localparam logic [4:0] SIG_ALU_NOR  = 5'd3;
   localparam logic [4:0] SIG_ALU_LUI  = 5'd4;
   localparam logic [4:0] SIG_ALU_SLL  = 5'd5;
   localparam logic [4:0] SIG_ALU_SRL  = 5'd6;
   localparam logic [4:0] SIG_ALU_SRA  = 5'd7;
   localparam logic [4:0] SIG_ALU_SLLV = 5'd8;
   localparam logic [4:0] SIG_ALU_SRLV = 5'd9;
   localparam logic [4:0] SIG_ALU_SRAV = 5'd10;
   localparam logic [4:0] SIG_ALU_FAIL = 5'd31;

   logic              valid_r;
   logic [4:0]        op_r;
   logic [DATA_W-1:0] srca_r;
   logic [DATA_W-1:0] srcb_r;
   logic [REG_W-1:0]  sa_r;
   logic [REG_W-1:0]  writereg_r;
   logic              regwrite_r;

   logic [DATA_W-1:0] opa_s;
   logic [DATA_W-1:0] opb_s;
   logic [DATA_W-1:0] result_s;
   logic              ri_s;
   logic              regwrite_gated_s;

   logic              validm_r;
   logic [DATA_W-1:0] resultm_r;
   logic [REG_W-1:0]  writeregm_r;
   logic              regwritem_r;
   logic              rim_r;

   // ID/EX register: flush beats stall, stall holds every field
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r    <= 1'b0;
         op_r       <= 5'd0;
         srca_r     <= '0;
         srcb_r     <= '0;
         sa_r       <= '0;
         writereg_r <= '0;
         regwrite_r <= 1'b0;
      end else if (flushE) begin
         valid_r    <= 1'b0;
         op_r       <= 5'd0;
         srca_r     <= '0;
         srcb_r     <= '0;
         sa_r       <= '0;
         writereg_r <= '0;
         regwrite_r <= 1'b0;
      end else if (!stallE) begin
         valid_r    <= validD;
         op_r       <= alucontrolD;
         srca_r     <= srcaD;
         srcb_r     <= srcbD;
         sa_r       <= saD;
         writereg_r <= writeregD;
         regwrite_r <= regwriteD;
      end
   end

`ifdef EX_BYPASS_EN
   logic [REG_W-1:0] rs_r;
   logic [REG_W-1:0] rt_r;
   logic             fwd_ok_s;

   // Source indices travel alongside the operands for the bypass compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_r <= '0;
         rt_r <= '0;
      end else if (flushE) begin
         rs_r <= '0;
         rt_r <= '0;
      end else if (!stallE) begin
         rs_r <= rsD;
         rt_r <= rtD;
      end
   end

   // Bypass from EX/MEM; a bubble or a write to $0 never forwards, LUI keeps its immediate
   always_comb begin
      fwd_ok_s = validM & regwriteM & (writeregM != '0);
      opa_s    = srca_r;
      opb_s    = srcb_r;
      if (fwd_ok_s && (writeregM == rs_r)) begin
         opa_s = aluresultM;
      end else begin
         opa_s = srca_r;
      end
      if (fwd_ok_s && (writeregM == rt_r) && (op_r != SIG_ALU_LUI)) begin
         opb_s = aluresultM;
      end else begin
         opb_s = srcb_r;
      end
   end
`else
   logic unused_idx_s;
   assign unused_idx_s = ^{rsD, rtD};

   // Operands used as latched; forwarding is resolved upstream
   always_comb begin
      opa_s = srca_r;
      opb_s = srcb_r;
   end
`endif

   // ALU; unknown codes produce 0 and raise a reserved-instruction flag for real instructions
   always_comb begin
      result_s = '0;
      ri_s     = 1'b0;
      case (op_r)
         SIG_ALU_AND:  result_s = opa_s & opb_s;
         SIG_ALU_OR:   result_s = opa_s | opb_s;
         SIG_ALU_XOR:  result_s = opa_s ^ opb_s;
         SIG_ALU_NOR:  result_s = ~(opa_s | opb_s);
         SIG_ALU_LUI:  result_s = {opb_s[15:0], {(DATA_W-16){1'b0}}};
         SIG_ALU_SLL:  result_s = opb_s << sa_r;
         SIG_ALU_SRL:  result_s = opb_s >> sa_r;
         SIG_ALU_SRA:  result_s = $signed(opb_s) >>> sa_r;
         SIG_ALU_SLLV: result_s = opb_s << opa_s[REG_W-1:0];
         SIG_ALU_SRLV: result_s = opb_s >> opa_s[REG_W-1:0];
         SIG_ALU_SRAV: result_s = $signed(opb_s) >>> opa_s[REG_W-1:0];
         SIG_ALU_FAIL: begin
            result_s = '0;
            ri_s     = valid_r;
         end
         default: begin
            result_s = '0;
            ri_s     = valid_r;
         end
      endcase
   end

   assign regwrite_gated_s = regwrite_r & valid_r & ~ri_s;
   assign aluresultE       = result_s;
   assign writeregE        = writereg_r;
   assign regwriteE        = regwrite_gated_s;

   // EX/MEM register: never stalls, a stalled EX sends a bubble downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validm_r    <= 1'b0;
         resultm_r   <= '0;
         writeregm_r <= '0;
         regwritem_r <= 1'b0;
         rim_r       <= 1'b0;
      end else if (stallE) begin
         validm_r    <= 1'b0;
         resultm_r   <= '0;
         writeregm_r <= '0;
         regwritem_r <= 1'b0;
         rim_r       <= 1'b0;
      end else begin
         validm_r    <= valid_r;
         resultm_r   <= result_s;
         writeregm_r <= writereg_r;
         regwritem_r <= regwrite_gated_s;
         rim_r       <= ri_s;
      end
   end

   assign validM     = validm_r;
   assign aluresultM = resultm_r;
   assign writeregM  = writeregm_r;
   assign regwriteM  = regwritem_r;
   assign ri_exceptM = rim_r;

endmodule
